// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: byte width and the
// encodings of the send sequencer states.
package uart_pkg;

  // Byte width carried between the buffer and the transmitter.
  localparam int DATA_W = 8;

  // Send sequencer state register type and encodings.
  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered head-data output.
// head_data is loaded from the array only when an entry is popped, so it
// holds the most recently popped byte until the next pop. Push is ignored
// while full and pop is ignored while empty, so count can neither wrap
// past DEPTH nor drop below zero.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp_reg;
  logic [AW-1:0]     rp_reg;
  logic [AW:0]       count_reg;
  logic [DATA_W-1:0] head_reg;
  logic              push_en;
  logic              pop_en;

  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = head_reg;

  // A full FIFO refuses the write even when a pop happens in the same cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Storage array write port; kept reset-free so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wp_reg] <= push_data;
    end
  end

  // Registered read port: captures the head entry on each pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg <= '0;
    end else if (pop_en) begin
      head_reg <= mem[rp_reg];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push_en) begin
        wp_reg <= wp_reg + 1'b1;
      end
      if (pop_en) begin
        rp_reg <= rp_reg + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and send sequencer in front of a UART transmitter.
// Producer bytes enter a FIFO over valid/ready; the sequencer pops one
// byte, pulses tx_send for one cycle, then waits for the transmitter's
// tx_sent pulse before taking the next byte.
// Build option: define UART_TX_FIFO_OVERFLOW_EN to enable the sticky
// overflow flag (a write attempt while full sets it; clr_overflow clears
// it; set wins over clear). Without it, overflow is tied low.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              tx_busy,
  input  logic              tx_sent,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_data,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  input  logic              clr_overflow
);

  import uart_pkg::*;

  state_t            state_reg;
  state_t            state_next;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [AW:0]       fifo_count;
  logic [DATA_W-1:0] head_data;

  // Readiness is taken from the registered full flag only, so a pop never
  // opens a slot for a write within the same cycle.
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && !fifo_full;

  // A byte is taken only when the sequencer is idle and the line is free.
  assign pop = (state_reg == S_IDLE) && !fifo_empty && !tx_busy;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign count = fifo_count;
  assign empty = fifo_empty;
  assign full  = fifo_full;

  // The FIFO's read register only changes on a pop, so it already holds
  // the byte steady for the transmitter from pop until the next pop.
  assign tx_data = head_data;
  assign tx_send = (state_reg == S_SEND);

  // Next-state logic: tx_busy matters only in IDLE, tx_sent only in WAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (pop) state_next = S_SEND;
      S_SEND:  state_next = S_WAIT;
      S_WAIT:  if (tx_sent) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_reg;

  // Sticky overflow: a write offered while full is dropped and flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (wr_valid && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;
`else
  logic unused_clr_overflow;

  assign unused_clr_overflow = clr_overflow;
  assign overflow            = 1'b0;
`endif

endmodule
